// File: rtl/svn_scan_ctrl.sv
// svn_scan_ctrl: time-multiplexed scan for a 4-digit common-anode display.
// Writes land in a shadow copy and move to the displayed copy only at a frame
// boundary, or straight away while the display is dark, so no frame ever
// shows a mix of old and new digits.
//
// Scan position (cnt_q, idx_q):
//   state                | meaning
//   cnt_q < DEAD_CYC     | dead time, all anodes off, digit already driven
//   cnt_q >= DEAD_CYC    | anode idx_q lit
//   idx_q==3, cnt_q==max | last cycle of frame, commit point
module svn_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_val_q, shadow_val_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic          pending_q, pending_d;

  logic          cnt_last;
  logic          commit;
  logic [3:0]    nibble;
  logic          lead_zero;

  assign cnt_last   = (cnt_q == CNT_LAST);
  assign frame_done = enable & (idx_q == 2'd3) & cnt_last;
  // while dark there is no frame to tear, so commit immediately
  assign commit     = pending_q & (frame_done | ~enable);

  // next-state: scan position, shadow/active registers and pending flag
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pending_d    = pending_q;

    if (!enable) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_last) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // active takes the pre-edge shadow; a same-edge write stays pending
    if (commit) begin
      act_val_d = shadow_val_q;
      act_dp_d  = shadow_dp_q;
      pending_d = 1'b0;
    end
    if (wr_en) begin
      shadow_val_d = wr_data;
      shadow_dp_d  = wr_dp;
      pending_d    = 1'b1;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      act_val_q    <= 16'h0000;
      act_dp_q     <= 4'h0;
      pending_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pending_q    <= pending_d;
    end
  end

  // leading-zero detect: this digit and every digit to its left are zero
  always_comb begin
    lead_zero = 1'b0;
    case (idx_q)
      2'd1:    lead_zero = (act_val_q[15:4] == 12'h000);
      2'd2:    lead_zero = (act_val_q[15:8] == 8'h00);
      2'd3:    lead_zero = (act_val_q[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  end

  assign nibble = act_val_q[{idx_q, 2'b00} +: 4];

  // output decode straight from registered state
  always_comb begin
    an    = 4'b1111;
    digit = 4'hF;
    dp_n  = 1'b1;
    if (enable) begin
      if (cnt_q >= CNT_DEAD) begin
        an = ~(4'b0001 << idx_q);
      end
      digit = (blank_lz && lead_zero) ? 4'hF : nibble;
      dp_n  = ~act_dp_q[idx_q];
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_svn_scan_ctrl.sv
// Bench for svn_scan_ctrl with REFRESH_DIV=8, DEAD_CYC=2. The reference model
// tracks time since scan start, the shadow/active values and the pending flag,
// and derives the expected outputs arithmetically from that.
module tb_svn_scan_ctrl;

  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FR = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic [3:0]  wr_dp = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dp_n;
  logic        pending;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int          m_t = 0;
  logic [15:0] m_sh_val = '0, m_act_val = '0;
  logic [3:0]  m_sh_dp = '0, m_act_dp = '0;
  logic        m_pend = 1'b0;

  logic [10:0] got, exp_v;

  svn_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
    .wr_data(wr_data), .wr_dp(wr_dp), .blank_lz(blank_lz),
    .an(an), .digit(digit), .dp_n(dp_n), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // expected {an, digit, dp_n, pending, frame_done}
  function automatic logic [10:0] exp_out();
    int slot = (m_t / RD) % 4;
    int pos  = m_t % RD;
    logic [15:0] upper;
    logic [3:0] a, d;
    logic p, f;
    upper = m_act_val >> (4 * slot);
    if (!enable) begin
      a = 4'hF; d = 4'hF; p = 1'b1; f = 1'b0;
    end else begin
      a = (pos < DC) ? 4'hF : 4'(~(1 << slot));
      d = (blank_lz && slot != 0 && upper == 16'h0) ? 4'hF : upper[3:0];
      p = ~m_act_dp[slot];
      f = (slot == 3) && (pos == RD - 1);
    end
    return {a, d, p, m_pend, f};
  endfunction

  task automatic model_edge();
    logic fd, com;
    fd = enable && ((m_t % FR) == FR - 1);
    if (!rst_n) begin
      m_t = 0; m_sh_val = '0; m_sh_dp = '0; m_act_val = '0; m_act_dp = '0; m_pend = 1'b0;
    end else begin
      com = m_pend && (fd || !enable);
      if (com) begin
        m_act_val = m_sh_val; m_act_dp = m_sh_dp;
      end
      if (wr_en) begin
        m_sh_val = wr_data; m_sh_dp = wr_dp; m_pend = 1'b1;
      end else if (com) begin
        m_pend = 1'b0;
      end
      m_t = enable ? (m_t + 1) % FR : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] v, input logic [3:0] d);
    wr_en = 1'b1; wr_data = v; wr_dp = d;
  endtask

  task automatic test_reset();
    enable = 1'b1; rst_n = 1'b0; blank_lz = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset cyc=%0d got=%b exp=%b", i, got, exp_v); end
      n_cmp++;
      if (got !== 11'b1111_0000_1_0_0) begin n_err++; $display("FAIL reset_const cyc=%0d got=%b exp=%b", i, got, 11'b1111_0000_1_0_0); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 3 * FR; i++) begin
      if (i == 0) do_write(16'h1234, 4'b0100);
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL scan cyc=%0d got=%b exp=%b", i, got, exp_v); end
      tick();
    end
  endtask

  task automatic test_tear_free();
    bit done = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      if (!done && (m_t % FR) == RD + 1) begin do_write(16'h5678, 4'($urandom)); done = 1; end
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL tear_free cyc=%0d got=%b exp=%b", i, got, exp_v); end
      tick();
    end
  endtask

  task automatic test_commit_edge();
    int ph = 0;
    for (int i = 0; i < 5 * FR; i++) begin
      if (ph == 0 && (m_t % FR) == 5) begin do_write(16'hAAAA, 4'b0001); ph = 1; end
      else if (ph == 1 && (m_t % FR) == FR - 1) begin do_write(16'hBBBB, 4'b1000); ph = 2; end
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL commit_edge cyc=%0d got=%b exp=%b", i, got, exp_v); end
      tick();
    end
  endtask

  task automatic test_lz();
    int base = -1;
    int k;
    for (int i = 0; i < 5 * FR + 8; i++) begin
      if (base < 0 && (m_t % FR) == 0) base = i;
      if (base >= 0) begin
        k = i - base;
        if (k == 0) do_write(16'h0040, 4'b0000);
        if (k == 2 * FR) do_write(16'h0000, 4'b0010);
        blank_lz = (k < 2 * FR || k >= 3 * FR);
      end
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL lead_zero cyc=%0d got=%b exp=%b", i, got, exp_v); end
      tick();
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_disable();
    int k = -1;
    for (int i = 0; i < 3 * FR; i++) begin
      if (k < 0 && (m_t % FR) == 2 * RD + 3) begin enable = 1'b0; k = 0; end
      if (k == 3) do_write(16'h9F01, 4'($urandom));
      if (k == 8) enable = 1'b1;
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL disable cyc=%0d got=%b exp=%b", i, got, exp_v); end
      tick();
      if (k >= 0) k++;
    end
    enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    int ph = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      rst_n = 1'b1;
      if (ph == 0 && (m_t % FR) == 2 * RD + 4) begin do_write(16'h4321, 4'b1111); ph = 1; end
      else if (ph == 1 && (m_t % FR) == 3 * RD + 3) begin rst_n = 1'b0; ph = 2; end
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL mid_reset cyc=%0d got=%b exp=%b", i, got, exp_v); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 119) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 2) == 0) do_write(16'($urandom) & 16'h00FF, 4'($urandom));
        else do_write(16'($urandom), 4'($urandom));
      end
      @(negedge clk);
      got = {an, digit, dp_n, pending, frame_done}; exp_v = exp_out(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got, exp_v); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_scan();
    test_tear_free();
    test_commit_edge();
    test_lz();
    test_disable();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
